// File: rtl/alu_operand_stage.sv
// ALU operand-B stage: selects register, shift amount or extended immediate,
// forwards EX/WB results at acceptance, and buffers operands in a 2-entry skid FIFO.
module alu_operand_stage #(
  parameter int DATA_W  = 32,
  parameter int IMM_W   = 16,
  parameter int SHAMT_W = 5,
  parameter int REG_AW  = 5,
  parameter int STALL_W = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               flush,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [1:0]         sel,
  input  logic [DATA_W-1:0]  regt,
  input  logic [REG_AW-1:0]  rt_addr,
  input  logic [SHAMT_W-1:0] shamt,
  input  logic [IMM_W-1:0]   imm,
  input  logic               ex_wr_en,
  input  logic [REG_AW-1:0]  ex_wr_addr,
  input  logic [DATA_W-1:0]  ex_wr_data,
  input  logic               wb_wr_en,
  input  logic [REG_AW-1:0]  wb_wr_addr,
  input  logic [DATA_W-1:0]  wb_wr_data,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [DATA_W-1:0]  outp,
  output logic [1:0]         out_fwd,
  output logic [STALL_W-1:0] stall_cnt
);

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_FULL  = 2'd2
  } state_e;

  localparam logic [1:0] FWD_NONE = 2'b00;
  localparam logic [1:0] FWD_EX   = 2'b01;
  localparam logic [1:0] FWD_WB   = 2'b10;

  function automatic logic [DATA_W-1:0] sext_imm(input logic [IMM_W-1:0] v);
    sext_imm = {{(DATA_W-IMM_W){v[IMM_W-1]}}, v};
  endfunction

  function automatic logic [DATA_W-1:0] zext_imm(input logic [IMM_W-1:0] v);
    zext_imm = {{(DATA_W-IMM_W){1'b0}}, v};
  endfunction

  function automatic logic [DATA_W-1:0] zext_shamt(input logic [SHAMT_W-1:0] v);
    zext_shamt = {{(DATA_W-SHAMT_W){1'b0}}, v};
  endfunction

  state_e              state_q, state_d;
  logic [DATA_W-1:0]   head_q, head_d;
  logic [1:0]          head_fwd_q, head_fwd_d;
  logic [DATA_W-1:0]   skid_q, skid_d;
  logic [1:0]          skid_fwd_q, skid_fwd_d;
  logic [STALL_W-1:0]  stall_q, stall_d;

  logic [DATA_W-1:0]   opnd_s;
  logic [1:0]          fwd_s;
  logic                push_s;
  logic                pop_s;
  logic                ex_hit_s;
  logic                wb_hit_s;

  assign in_ready  = (state_q != ST_FULL);
  assign out_valid = (state_q != ST_EMPTY);
  assign outp      = head_q;
  assign out_fwd   = head_fwd_q;
  assign stall_cnt = stall_q;

  assign push_s = in_valid && in_ready;
  assign pop_s  = out_valid && out_ready;

  // Register 0 is hardwired, so a write to it must never be forwarded.
  assign ex_hit_s = ex_wr_en && (ex_wr_addr == rt_addr) && (rt_addr != {REG_AW{1'b0}});
  assign wb_hit_s = wb_wr_en && (wb_wr_addr == rt_addr) && (rt_addr != {REG_AW{1'b0}});

  // Operand formation: select, extend and forward the incoming request.
  always_comb begin
    opnd_s = regt;
    fwd_s  = FWD_NONE;
    case (sel)
      2'b01: opnd_s = zext_shamt(shamt);
      2'b10: opnd_s = sext_imm(imm);
      2'b11: opnd_s = zext_imm(imm);
      2'b00: begin
        if (ex_hit_s) begin
          opnd_s = ex_wr_data;
          fwd_s  = FWD_EX;
        end else if (wb_hit_s) begin
          opnd_s = wb_wr_data;
          fwd_s  = FWD_WB;
        end else begin
          opnd_s = regt;
          fwd_s  = FWD_NONE;
        end
      end
      default: begin
        opnd_s = regt;
        fwd_s  = FWD_NONE;
      end
    endcase
  end

  // FIFO next-state: head feeds the output registers, skid holds the second entry.
  always_comb begin
    state_d    = state_q;
    head_d     = head_q;
    head_fwd_d = head_fwd_q;
    skid_d     = skid_q;
    skid_fwd_d = skid_fwd_q;
    if (flush) begin
      state_d = ST_EMPTY;
    end else begin
      case (state_q)
        ST_EMPTY: begin
          if (push_s) begin
            state_d    = ST_ONE;
            head_d     = opnd_s;
            head_fwd_d = fwd_s;
          end else begin
            state_d = ST_EMPTY;
          end
        end
        ST_ONE: begin
          if (push_s && pop_s) begin
            head_d     = opnd_s;
            head_fwd_d = fwd_s;
          end else if (push_s) begin
            state_d    = ST_FULL;
            skid_d     = opnd_s;
            skid_fwd_d = fwd_s;
          end else if (pop_s) begin
            state_d = ST_EMPTY;
          end else begin
            state_d = ST_ONE;
          end
        end
        ST_FULL: begin
          if (pop_s) begin
            state_d    = ST_ONE;
            head_d     = skid_q;
            head_fwd_d = skid_fwd_q;
          end else begin
            state_d = ST_FULL;
          end
        end
        default: state_d = ST_EMPTY;
      endcase
    end
  end

  // Saturating backpressure counter; only reset clears it.
  always_comb begin
    stall_d = stall_q;
    if (out_valid && !out_ready && (stall_q != {STALL_W{1'b1}})) begin
      stall_d = stall_q + {{(STALL_W-1){1'b0}}, 1'b1};
    end else begin
      stall_d = stall_q;
    end
  end

  // State and data registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_EMPTY;
      head_q     <= {DATA_W{1'b0}};
      head_fwd_q <= FWD_NONE;
      skid_q     <= {DATA_W{1'b0}};
      skid_fwd_q <= FWD_NONE;
      stall_q    <= {STALL_W{1'b0}};
    end else begin
      state_q    <= state_d;
      head_q     <= head_d;
      head_fwd_q <= head_fwd_d;
      skid_q     <= skid_d;
      skid_fwd_q <= skid_fwd_d;
      stall_q    <= stall_d;
    end
  end

endmodule

// File: tb/tb_alu_operand_stage.sv
// Directed-vector bench for alu_operand_stage, built with STALL_W=4 so the
// stall counter saturates within a short run.
module tb_alu_operand_stage;

  localparam int DATA_W  = 32;
  localparam int IMM_W   = 16;
  localparam int SHAMT_W = 5;
  localparam int REG_AW  = 5;
  localparam int STALL_W = 4;

  logic               clk;
  logic               rst_n;
  logic               flush;
  logic               in_valid;
  logic               in_ready;
  logic [1:0]         sel;
  logic [DATA_W-1:0]  regt;
  logic [REG_AW-1:0]  rt_addr;
  logic [SHAMT_W-1:0] shamt;
  logic [IMM_W-1:0]   imm;
  logic               ex_wr_en;
  logic [REG_AW-1:0]  ex_wr_addr;
  logic [DATA_W-1:0]  ex_wr_data;
  logic               wb_wr_en;
  logic [REG_AW-1:0]  wb_wr_addr;
  logic [DATA_W-1:0]  wb_wr_data;
  logic               out_valid;
  logic               out_ready;
  logic [DATA_W-1:0]  outp;
  logic [1:0]         out_fwd;
  logic [STALL_W-1:0] stall_cnt;

  int n_vec;
  int n_err;

  alu_operand_stage #(
    .DATA_W (DATA_W),
    .IMM_W  (IMM_W),
    .SHAMT_W(SHAMT_W),
    .REG_AW (REG_AW),
    .STALL_W(STALL_W)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .sel       (sel),
    .regt      (regt),
    .rt_addr   (rt_addr),
    .shamt     (shamt),
    .imm       (imm),
    .ex_wr_en  (ex_wr_en),
    .ex_wr_addr(ex_wr_addr),
    .ex_wr_data(ex_wr_data),
    .wb_wr_en  (wb_wr_en),
    .wb_wr_addr(wb_wr_addr),
    .wb_wr_data(wb_wr_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .outp      (outp),
    .out_fwd   (out_fwd),
    .stall_cnt (stall_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec = n_vec + 1;
    if (obs !== exp) begin
      n_err = n_err + 1;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One request with out_ready high: visible next cycle, gone the cycle after.
  task automatic single(input string tag, input logic [1:0] s, input logic [31:0] exp_v,
                        input logic [1:0] exp_f);
    sel       = s;
    in_valid  = 1'b1;
    out_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    chk({tag, "_valid"}, 32'(out_valid), 32'd1);
    chk({tag, "_outp"}, outp, exp_v);
    chk({tag, "_fwd"}, 32'(out_fwd), 32'(exp_f));
    tick();
    chk({tag, "_drain"}, 32'(out_valid), 32'd0);
  endtask

  initial begin
    n_vec      = 0;
    n_err      = 0;
    rst_n      = 1'b0;
    flush      = 1'b0;
    in_valid   = 1'b0;
    out_ready  = 1'b1;
    sel        = 2'b00;
    regt       = 32'd0;
    rt_addr    = 5'd0;
    shamt      = 5'd0;
    imm        = 16'd0;
    ex_wr_en   = 1'b0;
    ex_wr_addr = 5'd0;
    ex_wr_data = 32'd0;
    wb_wr_en   = 1'b0;
    wb_wr_addr = 5'd0;
    wb_wr_data = 32'd0;

    #22;
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_outp", outp, 32'd0);
    chk("rst_fwd", 32'(out_fwd), 32'd0);
    chk("rst_stall", 32'(stall_cnt), 32'd0);
    rst_n = 1'b1;
    tick();
    chk("rst_in_ready", 32'(in_ready), 32'd1);

    // Immediate paths ignore a matching EX write.
    rt_addr    = 5'd3;
    ex_wr_en   = 1'b1;
    ex_wr_addr = 5'd3;
    ex_wr_data = 32'hDEAD_BEEF;
    imm        = 16'hFFF0;
    single("sext", 2'b10, 32'hFFFF_FFF0, 2'b00);
    imm = 16'h8001;
    single("zext", 2'b11, 32'h0000_8001, 2'b00);
    shamt = 5'd31;
    single("shamt", 2'b01, 32'h0000_001F, 2'b00);

    regt       = 32'd1;
    rt_addr    = 5'd7;
    ex_wr_en   = 1'b1;
    ex_wr_addr = 5'd7;
    ex_wr_data = 32'hAAAA_0000;
    wb_wr_en   = 1'b1;
    wb_wr_addr = 5'd7;
    wb_wr_data = 32'h0000_5555;
    single("fwd_ex", 2'b00, 32'hAAAA_0000, 2'b01);
    ex_wr_en = 1'b0;
    single("fwd_wb", 2'b00, 32'h0000_5555, 2'b10);
    ex_wr_en   = 1'b1;
    ex_wr_addr = 5'd0;
    wb_wr_addr = 5'd0;
    rt_addr    = 5'd0;
    regt       = 32'h1234_5678;
    single("fwd_r0", 2'b00, 32'h1234_5678, 2'b00);
    ex_wr_en = 1'b0;
    wb_wr_en = 1'b0;

    // Backpressure: three back-to-back requests while the ALU stalls.
    sel       = 2'b11;
    out_ready = 1'b0;
    in_valid  = 1'b1;
    imm       = 16'd1;
    tick();
    imm = 16'd2;
    tick();
    chk("bp_in_ready_full", 32'(in_ready), 32'd0);
    chk("bp_head1", outp, 32'd1);
    imm = 16'd3;
    tick();
    chk("bp_stall2", 32'(stall_cnt), 32'd2);
    chk("bp_hold1", outp, 32'd1);
    out_ready = 1'b1;
    tick();
    chk("bp_head2", outp, 32'd2);
    chk("bp_in_ready_one", 32'(in_ready), 32'd1);
    tick();
    in_valid = 1'b0;
    chk("bp_head3", outp, 32'd3);
    chk("bp_valid3", 32'(out_valid), 32'd1);
    tick();
    chk("bp_empty", 32'(out_valid), 32'd0);
    chk("bp_stall_kept", 32'(stall_cnt), 32'd2);

    // Flush with the buffer full and a simultaneous request.
    out_ready = 1'b0;
    in_valid  = 1'b1;
    imm       = 16'h0011;
    tick();
    imm = 16'h0022;
    tick();
    chk("fl_full", 32'(in_ready), 32'd0);
    flush = 1'b1;
    imm   = 16'h0033;
    tick();
    flush    = 1'b0;
    in_valid = 1'b0;
    chk("fl_valid", 32'(out_valid), 32'd0);
    chk("fl_in_ready", 32'(in_ready), 32'd1);
    chk("fl_outp_kept", outp, 32'h0000_0011);
    chk("fl_stall", 32'(stall_cnt), 32'd4);
    out_ready = 1'b1;
    tick();
    tick();
    chk("fl_no_ghost", 32'(out_valid), 32'd0);

    // Saturation: 2^STALL_W+3 stalled cycles from a count of 4.
    out_ready = 1'b0;
    in_valid  = 1'b1;
    imm       = 16'h0044;
    tick();
    in_valid = 1'b0;
    for (int i = 0; i < 5; i++) tick();
    chk("sat_mid", 32'(stall_cnt), 32'd9);
    for (int i = 0; i < 14; i++) tick();
    chk("sat_top", 32'(stall_cnt), 32'hF);
    tick();
    chk("sat_stick", 32'(stall_cnt), 32'hF);
    chk("sat_head", outp, 32'h0000_0044);

    // Asynchronous reset mid-cycle clears outputs without a clock edge.
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_valid", 32'(out_valid), 32'd0);
    chk("arst_outp", outp, 32'd0);
    chk("arst_stall", 32'(stall_cnt), 32'd0);
    chk("arst_fwd", 32'(out_fwd), 32'd0);
    #3;
    rst_n = 1'b1;
    tick();
    imm = 16'h7FFF;
    single("post_rst", 2'b10, 32'h0000_7FFF, 2'b00);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
